// File: rtl/led_ctrl_pkg.sv
// Shared state encoding, default timing and width helpers for the LED blink-code sequencer.
package led_ctrl_pkg;

    typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_t;

    localparam int unsigned DEF_TICK_DIV  = 2_500_000;
    localparam int unsigned DEF_ON_TICKS  = 2;
    localparam int unsigned DEF_OFF_TICKS = 3;
    localparam int unsigned DEF_GAP_TICKS = 10;
    localparam int unsigned DEF_CNT_W     = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running clock divider: tick is high for one cycle every TICK_DIV cycles.
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int unsigned DIV_W = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;

    assign tick = (cnt_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_code_sched.sv
// Blink-code sequencer: drives N on/off pulses then a dark gap, once or repeating.
module led_code_sched
    import led_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
    parameter int unsigned OFF_TICKS = DEF_OFF_TICKS,
    parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_repeat,
    output logic             led,
    output logic             busy,
    output logic             done
);
    localparam int unsigned PH_W = clog2(max3(ON_TICKS, OFF_TICKS, GAP_TICKS) + 1);
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             rep_q, rep_d;
    logic             led_q, done_q, done_d;
    logic             accept, tick, clr;

    assign cmd_ready = (state_q == StIdle) || ((state_q == StGap) && rep_q);
    assign accept    = cmd_valid && cmd_ready;
    assign led       = led_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    // A new command takes priority over the phase timer, including on the last GAP tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        if (accept) begin
            if (cmd_count != '0) begin
                state_d = StOn;
                cnt_d   = cmd_count;
                rem_d   = cmd_count;
                rep_d   = cmd_repeat;
            end else begin
                state_d = StIdle;
                rem_d   = '0;
                rep_d   = 1'b0;
                done_d  = 1'b1;
            end
        end else if (tick) begin
            unique case (state_q)
                StOn: begin
                    if (phase_q == ON_LAST) begin
                        state_d = StOff;
                        rem_d   = rem_q - CNT_W'(1);
                    end
                end
                StOff: begin
                    if (phase_q == OFF_LAST) state_d = (rem_q != '0) ? StOn : StGap;
                end
                StGap: begin
                    if (phase_q == GAP_LAST) begin
                        if (rep_q) begin
                            state_d = StOn;
                            rem_d   = cnt_q;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Restart both timers on any state change so every phase has its full length.
    assign clr = accept || (state_d != state_q);

    always_comb begin
        phase_d = phase_q;
        if (clr) begin
            phase_d = '0;
        end else if (tick && (state_q != StIdle)) begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            rep_q   <= 1'b0;
            phase_q <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            rep_q   <= rep_d;
            phase_q <= phase_d;
            led_q   <= (state_d == StOn);
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_led_code_sched.sv
// Scoreboard bench: each scenario queues the expected per-cycle {led,busy,done,cmd_ready}.
module tb_led_code_sched;

    localparam int ON_C  = 8;
    localparam int OFF_C = 12;
    localparam int GAP_C = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_repeat = 1'b0;
    logic [3:0] cmd_count = '0;
    logic       cmd_ready, led, busy, done;
    logic       f_valid = 1'b0, f_repeat = 1'b0;
    logic [3:0] f_count = '0;
    logic       f_ready, f_led, f_busy, f_done;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    led_code_sched #(
        .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(3), .GAP_TICKS(10), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_count(cmd_count), .cmd_repeat(cmd_repeat), .led(led), .busy(busy), .done(done)
    );

    led_code_sched #(
        .TICK_DIV(1), .ON_TICKS(2), .OFF_TICKS(3), .GAP_TICKS(10), .CNT_W(4)
    ) dut_fast (
        .clk(clk), .rst_n(rst_n), .cmd_valid(f_valid), .cmd_ready(f_ready),
        .cmd_count(f_count), .cmd_repeat(f_repeat), .led(f_led), .busy(f_busy), .done(f_done)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected vectors are {led, busy, done, cmd_ready}.
    function automatic void push_code(int n, bit rep, int on_c, int off_c, int gap_c);
        for (int p = 0; p < n; p++) begin
            repeat (on_c) sb.push_back(4'b1100);
            repeat (off_c) sb.push_back(4'b0100);
        end
        repeat (gap_c) sb.push_back({3'b010, rep});
        if (!rep) sb.push_back(4'b0011);
    endfunction

    task automatic test_reset();
        logic [3:0] obs;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            obs = {led, busy, done, cmd_ready};
            n_checks++;
            if (obs !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset: {led,busy,done,ready} got %b want 0001", obs);
            end
            obs = {f_led, f_busy, f_done, f_ready};
            n_checks++;
            if (obs !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset_fast: {led,busy,done,ready} got %b want 0001", obs);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        logic [3:0] exp, obs;
        repeat (1000) sb.push_back(4'b0001);
        while (sb.size() != 0) begin
            cycle();
            exp = sb.pop_front();
            obs = {led, busy, done, cmd_ready};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL idle: got %b want %b", obs, exp);
            end
        end
    endtask

    task automatic test_one_shot();
        logic [3:0] exp, obs;
        logic       rdy;
        int         idx = 0;
        cmd_count = 4'd3; cmd_repeat = 1'b0; cmd_valid = 1'b1;
        push_code(3, 1'b0, ON_C, OFF_C, GAP_C);
        repeat (2) sb.push_back(4'b0001);
        while (sb.size() != 0) begin
            rdy = cmd_ready;
            cycle();
            if (cmd_valid && rdy) cmd_valid = 1'b0;
            exp = sb.pop_front();
            obs = {led, busy, done, cmd_ready};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL one_shot: cycle %0d got %b want %b", idx, obs, exp);
            end
            idx++;
        end
    endtask

    task automatic test_repeat_stop();
        logic [3:0] exp, obs;
        logic       rdy;
        int         idx = 0;
        cmd_count = 4'd2; cmd_repeat = 1'b1; cmd_valid = 1'b1;
        push_code(2, 1'b1, ON_C, OFF_C, GAP_C);
        push_code(2, 1'b1, ON_C, OFF_C, GAP_C);
        push_code(2, 1'b1, ON_C, OFF_C, 20);
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                cmd_count = 4'd0; cmd_repeat = 1'b0; cmd_valid = 1'b1;
                sb.push_back(4'b0011);
                repeat (3) sb.push_back(4'b0001);
            end
            while (sb.size() != 0) begin
                rdy = cmd_ready;
                cycle();
                if (cmd_valid && rdy) cmd_valid = 1'b0;
                exp = sb.pop_front();
                obs = {led, busy, done, cmd_ready};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL repeat_stop: cycle %0d got %b want %b", idx, obs, exp);
                end
                idx++;
            end
        end
    endtask

    task automatic test_hold_during_on();
        logic [3:0] exp, obs;
        logic       rdy;
        int         idx = 0;
        cmd_count = 4'd2; cmd_repeat = 1'b1; cmd_valid = 1'b1;
        push_code(2, 1'b1, ON_C, OFF_C, 1);
        push_code(5, 1'b0, ON_C, OFF_C, GAP_C);
        sb.push_back(4'b0001);
        while (sb.size() != 0) begin
            rdy = cmd_ready;
            cycle();
            if (cmd_valid && rdy) cmd_valid = 1'b0;
            exp = sb.pop_front();
            obs = {led, busy, done, cmd_ready};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL hold_during_on: cycle %0d got %b want %b", idx, obs, exp);
            end
            if (idx == 3) begin
                cmd_count = 4'd5; cmd_repeat = 1'b0; cmd_valid = 1'b1;
            end
            idx++;
        end
    endtask

    task automatic test_reset_mid_code();
        logic [3:0] exp, obs;
        logic       rdy;
        int         idx = 0;
        cmd_count = 4'd4; cmd_repeat = 1'b0; cmd_valid = 1'b1;
        repeat (5) sb.push_back(4'b1100);
        while (sb.size() != 0) begin
            rdy = cmd_ready;
            cycle();
            if (cmd_valid && rdy) cmd_valid = 1'b0;
            exp = sb.pop_front();
            obs = {led, busy, done, cmd_ready};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_pre: cycle %0d got %b want %b", idx, obs, exp);
            end
            idx++;
        end
        #2 rst_n = 1'b0;
        #1;
        obs = {led, busy, done, cmd_ready};
        n_checks++;
        if (obs !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b want 0001", obs);
        end
        cycle();
        rst_n = 1'b1;
        idx = 0;
        repeat (3) sb.push_back(4'b0001);
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                cmd_count = 4'd1; cmd_repeat = 1'b0; cmd_valid = 1'b1;
                push_code(1, 1'b0, ON_C, OFF_C, GAP_C);
                sb.push_back(4'b0001);
            end
            while (sb.size() != 0) begin
                rdy = cmd_ready;
                cycle();
                if (cmd_valid && rdy) cmd_valid = 1'b0;
                exp = sb.pop_front();
                obs = {led, busy, done, cmd_ready};
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL reset_mid_post: cycle %0d got %b want %b", idx, obs, exp);
                end
                idx++;
            end
        end
    endtask

    task automatic test_fast_max_count();
        logic [3:0] exp, obs;
        logic       rdy;
        int         idx = 0;
        f_count = 4'd15; f_repeat = 1'b0; f_valid = 1'b1;
        push_code(15, 1'b0, 2, 3, 10);
        repeat (2) sb.push_back(4'b0001);
        while (sb.size() != 0) begin
            rdy = f_ready;
            cycle();
            if (f_valid && rdy) f_valid = 1'b0;
            exp = sb.pop_front();
            obs = {f_led, f_busy, f_done, f_ready};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL fast_max_count: cycle %0d got %b want %b", idx, obs, exp);
            end
            idx++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_idle();
        test_one_shot();
        test_repeat_stop();
        test_hold_during_on();
        test_reset_mid_code();
        test_fast_max_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
